fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  Parametrised instruction-fetch stage; replaces the fixed PC register + combinational inst_mem read.
//  Drives an instruction memory over a req/gnt/rvalid bus with up to MAX_OUTST requests in flight.
//  Buffers returned words with their PCs in a DEPTH-entry prefetch FIFO.
//  Hands them to decode over a valid/ready handshake; i_redirect (branch/jump) flushes the stream.
// PARAMETERS
//  RESET_PC   32'h0000_0000  fetch address after reset
//  DEPTH      4              prefetch FIFO entries; power of 2, >=2
//  MAX_OUTST  2              max granted-but-not-returned requests; 1..DEPTH
// PORTS
//  i_clk            in   1   clock, rising edge
//  i_rst_n          in   1   reset, synchronous, active-low
//  o_imem_req       out  1   fetch request valid
//  o_imem_addr      out  32  fetch byte address, word aligned
//  i_imem_gnt       in   1   request accepted this cycle
//  i_imem_rvalid    in   1   response valid; in order, max one per cycle
//  i_imem_rdata     in   32  response instruction word
//  i_redirect       in   1   flush and restart fetch at i_redirect_pc
//  i_redirect_pc    in   32  new fetch address
//  o_inst_vld       out  1   FIFO head valid to decode
//  i_inst_rdy       in   1   decode accepts head
//  o_inst           out  32  head instruction
//  o_pc             out  32  head PC
//  o_pc_4           out  32  head PC + 4, wraps mod 2^32
//  o_fetch_err      out  1   misaligned redirect flag; tied 0 unless FETCH_MISALIGN_EN
// BEHAVIOUR
//  - Reset values:
//    o_imem_req=0, o_inst_vld=0, o_fetch_err=0, o_inst/o_pc=0.
//    fetch_pc=RESET_PC, FIFO empty, outst=0, drop=0.
//  - Request generation:
//    o_imem_req=1 iff !i_redirect && !err && outst<MAX_OUTST && (fifo_cnt+outst)<DEPTH.
//    This credit rule guarantees every live response has a FIFO slot.
//  - o_imem_addr=fetch_pc. Address is held stable while req && !gnt.
//  - On req&&gnt: fetch_pc+=4 (mod 2^32); outst+=1.
//  - On rvalid: outst-=1.
//    drop>0: word discarded, drop-=1.
//    drop==0: {fetch-order PC, rdata} pushed into FIFO.
//  - Response PC: a separate in-flight PC queue (MAX_OUTST entries) records the PC at grant.
//  - Simultaneous gnt and rvalid: outst unchanged.
//  - Latency: gnt cycle N -> rvalid >= N+1 -> o_inst_vld at rvalid+1.
//    No FIFO bypass. Sustains 1 inst/cycle with a 1-cycle memory and MAX_OUTST>=2.
//  - Decode side: head popped on o_inst_vld && i_inst_rdy.
//    Outputs are held while vld && !rdy. Push and pop in the same cycle are both legal, including when full.
//  - Redirect (cycle R), priority over everything else:
//    * FIFO flushed; the pop that cycle is ignored. o_inst_vld=0 from R+1.
//    * Request suppressed in R.
//    * fetch_pc <= {i_redirect_pc[31:2],2'b00}.
//    * drop <= outst - i_imem_rvalid; any rvalid in R is discarded.
//    * Back-to-back redirects: each recomputes drop from the current outst.
//      The last redirect wins.
//  - First request after redirect: R+1.
//  - Reset mid-operation clears all state in 1 cycle. Memory responses in flight at reset must be
//    discarded by the memory; this is an integration requirement.
// CONFIGURATION
//  FETCH_MISALIGN_EN defined:
//    - Redirect with i_redirect_pc[1:0]!=0: FIFO flushed; o_fetch_err=1 from R+1.
//    - Requests stop.
//    - o_pc is set to the faulting i_redirect_pc.
//    - The flag is sticky until the next aligned redirect or reset.
//  FETCH_MISALIGN_EN undefined:
//    - Low 2 bits of i_redirect_pc silently cleared.
//    - o_fetch_err tied 0; no extra state.
// TESTING
//  1. Reset, RESET_PC=0, 1-cycle gnt/rvalid memory, rdy=1:
//     -> addrs 0,4,8,... on consecutive cycles. First o_inst_vld at cycle 3 with o_pc=0, o_pc_4=4.
//     -> Then 1 inst/cycle.
//  2. rdy=0 held:
//     -> at most DEPTH=4 responses buffered, req drops.
//     -> o_inst/o_pc stable. Releasing rdy yields PCs 0,4,8,12 in order, no loss or duplication.
//  3. Memory with 3-cycle rvalid latency, MAX_OUTST=2:
//     -> never more than 2 grants without a response. Order is preserved.
//  4. Redirect to 0x100 while 2 requests outstanding:
//     -> both late responses dropped. Next o_pc=0x100; no stale inst ever valid.
//  5. Redirect to 0x102:
//     -> with FETCH_MISALIGN_EN: o_fetch_err=1, o_imem_req=0, until a redirect to 0x200 clears it.
//     -> without FETCH_MISALIGN_EN: fetch resumes at 0x100.
//  6. fetch_pc=0xFFFF_FFFC:
//     -> next addr 0x0000_0000; o_pc_4 wraps to 0.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch with credit-limited imem requests and a prefetch FIFO.
// Optional macro FETCH_MISALIGN_EN: misaligned redirects raise a sticky o_fetch_err.
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          DEPTH     = 4,
    parameter int          MAX_OUTST = 2
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_gnt,
    input  logic        i_imem_rvalid,
    input  logic [31:0] i_imem_rdata,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    output logic        o_inst_vld,
    input  logic        i_inst_rdy,
    output logic [31:0] o_inst,
    output logic [31:0] o_pc,
    output logic [31:0] o_pc_4,
    output logic        o_fetch_err
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int OW = $clog2(MAX_OUTST + 1);
    localparam int QW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fifo_entry_t;

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [OW-1:0] outst_q, outst_d;
    logic [OW-1:0] drop_q, drop_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [QW-1:0] pq_wr_q, pq_wr_d;
    logic [QW-1:0] pq_rd_q, pq_rd_d;
    fifo_entry_t   fifo_q [DEPTH];
    fifo_entry_t   fifo_d [DEPTH];
    logic [31:0]   pcq_q [MAX_OUTST];
    logic [31:0]   pcq_d [MAX_OUTST];

    logic        err;
    logic        req;
    logic        fire;
    logic        push;
    logic        pop;
    logic [31:0] head_pc;

    function automatic logic [QW-1:0] qnext(input logic [QW-1:0] idx);
        return (idx == QW'(MAX_OUTST - 1)) ? '0 : idx + QW'(1);
    endfunction

`ifdef FETCH_MISALIGN_EN
    logic        err_q, err_d;
    logic [31:0] err_pc_q, err_pc_d;

    // Sticky misalign flag, captured with the faulting target on every redirect
    always_comb begin
        err_d    = err_q;
        err_pc_d = err_pc_q;
        if (i_redirect) begin
            err_d    = (i_redirect_pc[1:0] != 2'b00);
            err_pc_d = i_redirect_pc;
        end
    end

    // Misalign state registers
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            err_q    <= 1'b0;
            err_pc_q <= '0;
        end else begin
            err_q    <= err_d;
            err_pc_q <= err_pc_d;
        end
    end

    assign err         = err_q;
    assign o_fetch_err = err_q;
    assign o_pc        = err_q ? err_pc_q : head_pc;
`else
    logic unused_redirect_lsb;

    assign unused_redirect_lsb = ^i_redirect_pc[1:0];
    assign err                 = 1'b0;
    assign o_fetch_err         = 1'b0;
    assign o_pc                = head_pc;
`endif

    assign o_inst_vld  = (cnt_q != '0);
    assign head_pc     = o_inst_vld ? fifo_q[rptr_q].pc : '0;
    assign o_inst      = o_inst_vld ? fifo_q[rptr_q].inst : '0;
    assign o_pc_4      = o_pc + 32'd4;
    assign o_imem_req  = req;
    assign o_imem_addr = fetch_pc_q;

    // Request credit, in-flight PC queue, drop counter and FIFO next-state
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        outst_d    = outst_q;
        drop_d     = drop_q;
        cnt_d      = cnt_q;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        pq_wr_d    = pq_wr_q;
        pq_rd_d    = pq_rd_q;
        fifo_d     = fifo_q;
        pcq_d      = pcq_q;

        req  = i_rst_n && !i_redirect && !err
            && (outst_q < OW'(MAX_OUTST))
            && ((32'(cnt_q) + 32'(outst_q)) < 32'(DEPTH));
        fire = req && i_imem_gnt;
        push = i_imem_rvalid && (drop_q == '0) && !i_redirect;
        pop  = o_inst_vld && i_inst_rdy && !i_redirect;

        if (fire) begin
            fetch_pc_d     = fetch_pc_q + 32'd4;
            pcq_d[pq_wr_q] = fetch_pc_q;
            pq_wr_d        = qnext(pq_wr_q);
        end
        if (i_imem_rvalid) begin
            pq_rd_d = qnext(pq_rd_q);
        end

        unique case ({fire, i_imem_rvalid})
            2'b10:   outst_d = outst_q + OW'(1);
            2'b01:   outst_d = outst_q - OW'(1);
            default: outst_d = outst_q;
        endcase

        if (i_imem_rvalid && (drop_q != '0)) begin
            drop_d = drop_q - OW'(1);
        end

        if (push) begin
            fifo_d[wptr_q].pc   = pcq_q[pq_rd_q];
            fifo_d[wptr_q].inst = i_imem_rdata;
            wptr_d              = wptr_q + AW'(1);
        end
        if (pop) begin
            rptr_d = rptr_q + AW'(1);
        end

        unique case ({push, pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase

        if (i_redirect) begin
            fetch_pc_d = {i_redirect_pc[31:2], 2'b00};
            drop_d     = outst_q - OW'(i_imem_rvalid);
            cnt_d      = '0;
            wptr_d     = '0;
            rptr_d     = '0;
        end
    end

    // Control state with synchronous reset
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            fetch_pc_q <= RESET_PC;
            outst_q    <= '0;
            drop_q     <= '0;
            cnt_q      <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            pq_wr_q    <= '0;
            pq_rd_q    <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            outst_q    <= outst_d;
            drop_q     <= drop_d;
            cnt_q      <= cnt_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            pq_wr_q    <= pq_wr_d;
            pq_rd_q    <= pq_rd_d;
        end
    end

    // Payload storage; only read when its occupancy says it is live
    always_ff @(posedge i_clk) begin
        fifo_q <= fifo_d;
        pcq_q  <= pcq_d;
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed checks of fetch_unit against a small in-order memory model.
// Build with or without FETCH_MISALIGN_EN; the misaligned-redirect case adapts.
module tb_fetch_unit;
    logic        i_clk;
    logic        i_rst_n;
    logic        o_imem_req;
    logic [31:0] o_imem_addr;
    logic        i_imem_gnt;
    logic        i_imem_rvalid;
    logic [31:0] i_imem_rdata;
    logic        i_redirect;
    logic [31:0] i_redirect_pc;
    logic        o_inst_vld;
    logic        i_inst_rdy;
    logic [31:0] o_inst;
    logic [31:0] o_pc;
    logic [31:0] o_pc_4;
    logic        o_fetch_err;

    fetch_unit #(
        .RESET_PC  (32'h0000_0000),
        .DEPTH     (4),
        .MAX_OUTST (2)
    ) dut (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .o_imem_req    (o_imem_req),
        .o_imem_addr   (o_imem_addr),
        .i_imem_gnt    (i_imem_gnt),
        .i_imem_rvalid (i_imem_rvalid),
        .i_imem_rdata  (i_imem_rdata),
        .i_redirect    (i_redirect),
        .i_redirect_pc (i_redirect_pc),
        .o_inst_vld    (o_inst_vld),
        .i_inst_rdy    (i_inst_rdy),
        .o_inst        (o_inst),
        .o_pc          (o_pc),
        .o_pc_4        (o_pc_4),
        .o_fetch_err   (o_fetch_err)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int          n_chk;
    int          n_fail;
    int          cyc;
    int          lat;
    int          n_acc;
    int          max_out;
    logic        gnt_en;
    logic [31:0] exp_pc;
    logic [31:0] base;
    logic [31:0] mq_addr [$];
    int          mq_due [$];

    function automatic logic [31:0] exp_inst(input logic [31:0] pc);
        return pc ^ 32'hDEAD_BEEF;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Drive memory response/grant for the current cycle and let logic settle
    task automatic settle();
        i_imem_gnt = gnt_en;
        if (mq_addr.size() != 0 && mq_due[0] <= cyc) begin
            i_imem_rvalid = 1'b1;
            i_imem_rdata  = exp_inst(mq_addr[0]);
        end else begin
            i_imem_rvalid = 1'b0;
            i_imem_rdata  = '0;
        end
        #2;
    endtask

    // Book-keep this cycle's handshakes, then advance past the next edge
    task automatic clk_edge();
        if (o_imem_req && i_imem_gnt) begin
            mq_addr.push_back(o_imem_addr);
            mq_due.push_back(cyc + lat);
        end
        if (i_imem_rvalid) begin
            void'(mq_addr.pop_front());
            void'(mq_due.pop_front());
        end
        if (mq_addr.size() > max_out) max_out = mq_addr.size();
        if (!i_rst_n) begin
            exp_pc = 32'h0000_0000;
        end else if (i_redirect) begin
            exp_pc = {i_redirect_pc[31:2], 2'b00};
        end else if (o_inst_vld && i_inst_rdy) begin
            chk("stream_pc", o_pc, exp_pc);
            chk("stream_inst", o_inst, exp_inst(exp_pc));
            exp_pc = exp_pc + 32'd4;
            n_acc++;
        end
        @(posedge i_clk);
        #1;
        cyc++;
    endtask

    task automatic tick();
        settle();
        clk_edge();
    endtask

    // Leaves the bench in the settled phase of the cycle where vld was seen
    task automatic wait_vld(input string tag, input logic [31:0] pc_exp);
        for (int i = 0; i < 20; i++) begin
            settle();
            if (o_inst_vld || i == 19) break;
            clk_edge();
        end
        chk({tag, "_vld"}, 32'(o_inst_vld), 32'd1);
        chk(tag, o_pc, pc_exp);
    endtask

    task automatic redirect_to(input logic [31:0] pc);
        i_redirect    = 1'b1;
        i_redirect_pc = pc;
        settle();
        chk("redir_req_sup", 32'(o_imem_req), 32'd0);
        clk_edge();
        i_redirect    = 1'b0;
    endtask

    initial begin
        n_chk = 0; n_fail = 0; cyc = 0; lat = 1; n_acc = 0; max_out = 0;
        gnt_en = 1'b1; exp_pc = '0; base = '0;
        i_rst_n = 1'b0; i_imem_gnt = 1'b0; i_imem_rvalid = 1'b0;
        i_imem_rdata = '0; i_redirect = 1'b0; i_redirect_pc = '0;
        i_inst_rdy = 1'b1;

        tick();
        tick();
        settle();
        chk("rst_req", 32'(o_imem_req), 32'd0);
        chk("rst_vld", 32'(o_inst_vld), 32'd0);
        chk("rst_err", 32'(o_fetch_err), 32'd0);
        chk("rst_inst", o_inst, 32'd0);
        chk("rst_pc", o_pc, 32'd0);
        clk_edge();
        i_rst_n = 1'b1;

        // 1: back-to-back fetch, first valid in the third cycle
        settle();
        chk("t1_req", 32'(o_imem_req), 32'd1);
        chk("t1_addr0", o_imem_addr, 32'h0);
        chk("t1_vld_c1", 32'(o_inst_vld), 32'd0);
        clk_edge();
        settle();
        chk("t1_addr1", o_imem_addr, 32'h4);
        chk("t1_vld_c2", 32'(o_inst_vld), 32'd0);
        clk_edge();
        settle();
        chk("t1_addr2", o_imem_addr, 32'h8);
        chk("t1_vld_c3", 32'(o_inst_vld), 32'd1);
        chk("t1_pc", o_pc, 32'h0);
        chk("t1_pc4", o_pc_4, 32'h4);
        chk("t1_inst", o_inst, exp_inst(32'h0));
        clk_edge();
        for (int k = 4; k < 10; k++) begin
            settle();
            chk("t1_rate_vld", 32'(o_inst_vld), 32'd1);
            chk("t1_rate_pc", o_pc, 32'(4 * (k - 3)));
            clk_edge();
        end

        // 2: decode stall fills the FIFO and stops requests
        i_inst_rdy = 1'b0;
        for (int k = 0; k < 8; k++) begin
            settle();
            chk("t2_hold_vld", 32'(o_inst_vld), 32'd1);
            chk("t2_hold_pc", o_pc, exp_pc);
            chk("t2_hold_inst", o_inst, exp_inst(exp_pc));
            clk_edge();
        end
        settle();
        chk("t2_req_off", 32'(o_imem_req), 32'd0);
        chk("t2_outst", 32'(mq_addr.size()), 32'd0);
        base = exp_pc;
        gnt_en = 1'b0;
        i_inst_rdy = 1'b1;
        for (int k = 0; k < 4; k++) begin
            settle();
            chk("t2_drain_vld", 32'(o_inst_vld), 32'd1);
            chk("t2_addr_hold", o_imem_addr, base + 32'd16);
            clk_edge();
        end
        settle();
        chk("t2_empty", 32'(o_inst_vld), 32'd0);
        chk("t2_req_back", 32'(o_imem_req), 32'd1);
        clk_edge();
        gnt_en = 1'b1;

        // 3: 3-cycle memory, never more than two in flight
        lat = 3;
        max_out = 0;
        base = 32'(n_acc);
        for (int k = 0; k < 24; k++) tick();
        chk("t3_max_outst", 32'(max_out), 32'd2);
        chk("t3_progress", 32'(n_acc - int'(base) > 5), 32'd1);

        // 4: redirect with two requests in flight
        for (int k = 0; k < 10; k++) begin
            settle();
            if (mq_addr.size() == 2 || k == 9) break;
            clk_edge();
        end
        chk("t4_two_outst", 32'(mq_addr.size()), 32'd2);
        i_redirect    = 1'b1;
        i_redirect_pc = 32'h0000_0100;
        #1;
        chk("t4_req_sup", 32'(o_imem_req), 32'd0);
        clk_edge();
        i_redirect = 1'b0;
        settle();
        chk("t4_flush", 32'(o_inst_vld), 32'd0);
        wait_vld("t4_pc", 32'h0000_0100);
        clk_edge();
        for (int k = 0; k < 10; k++) tick();

        // 5: misaligned redirect from an idle bus
        lat = 1;
        gnt_en = 1'b0;
        for (int k = 0; k < 20; k++) begin
            settle();
            if (mq_addr.size() == 0 || k == 19) break;
            clk_edge();
        end
        chk("t5_idle", 32'(mq_addr.size()), 32'd0);
        clk_edge();
        gnt_en = 1'b1;
        redirect_to(32'h0000_0102);
        settle();
`ifdef FETCH_MISALIGN_EN
        chk("t5_err", 32'(o_fetch_err), 32'd1);
        chk("t5_req", 32'(o_imem_req), 32'd0);
        chk("t5_err_pc", o_pc, 32'h0000_0102);
        chk("t5_vld", 32'(o_inst_vld), 32'd0);
        clk_edge();
        for (int k = 0; k < 3; k++) begin
            settle();
            chk("t5_err_sticky", 32'(o_fetch_err), 32'd1);
            chk("t5_req_stop", 32'(o_imem_req), 32'd0);
            clk_edge();
        end
        redirect_to(32'h0000_0200);
        settle();
        chk("t5_err_clr", 32'(o_fetch_err), 32'd0);
        chk("t5_req_r1", 32'(o_imem_req), 32'd1);
        chk("t5_addr_r1", o_imem_addr, 32'h0000_0200);
        clk_edge();
        wait_vld("t5_pc", 32'h0000_0200);
        clk_edge();
`else
        chk("t5_err", 32'(o_fetch_err), 32'd0);
        chk("t5_req_r1", 32'(o_imem_req), 32'd1);
        chk("t5_addr_r1", o_imem_addr, 32'h0000_0100);
        clk_edge();
        wait_vld("t5_pc", 32'h0000_0100);
        clk_edge();
`endif
        for (int k = 0; k < 4; k++) tick();

        // 6: fetch address and PC+4 wrap at the top of the space
        redirect_to(32'hFFFF_FFFC);
        wait_vld("t6_pc", 32'hFFFF_FFFC);
        chk("t6_pc4", o_pc_4, 32'h0000_0000);
        clk_edge();
        wait_vld("t6_wrap_pc", 32'h0000_0000);
        chk("t6_wrap_pc4", o_pc_4, 32'h0000_0004);
        clk_edge();
        for (int k = 0; k < 6; k++) tick();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
